dieu_khien_xung: RTL and testbench

DIEU_KHIEN_XUNG -- requirements
Module: dieu_khien_xung

---
 rtl/dieu_khien_xung.sv | 134 +++++++++++++
 tb/tb_dieu_khien_xung.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dieu_khien_xung.sv
// Three-channel tick/square-wave generator with continuous and counted-burst modes.
// Burst mode (BURST/DONE states, done pulse) is built only when BURST_MODE_EN is defined.
module dieu_khien_xung #(
  parameter int DIV0 = 100000000,
  parameter int DIV1 = 50000000,
  parameter int DIV2 = 25000000
) (
  input  logic       clki,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       burst,
  input  logic [1:0] sel,
  input  logic [7:0] burst_len,
  output logic [2:0] tick,
  output logic [2:0] sq,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, BURST, DONE} state_t;

  state_t      state;
  logic [1:0]  sel_l;
  logic [7:0]  len_l;
  logic [7:0]  bcnt;
  logic [2:0]  tick_nx;
  logic        burst_req;
  logic [1:0]  sel_in;
  logic [7:0]  len_in;
  logic        active;
  logic        go;
  logic        tick_sel;
  logic        finish;
  logic        stay;
  logic        run_nx;

`ifdef BURST_MODE_EN
  assign burst_req = burst;
  assign sel_in    = (sel == 2'd3) ? 2'd0 : sel;
  assign len_in    = burst_len;
`else
  logic unused_cfg;
  assign unused_cfg = ^{burst, sel, burst_len};
  assign burst_req  = 1'b0;
  assign sel_in     = 2'd0;
  assign len_in     = 8'd0;
`endif

  assign active = (state == RUN) || (state == BURST);
  assign go     = (state == IDLE) && start && !stop;

  always_comb begin
    tick_sel = tick[0];
    case (sel_l)
      2'd1:    tick_sel = tick[1];
      2'd2:    tick_sel = tick[2];
      default: tick_sel = tick[0];
    endcase
  end

  // Burst ends at the edge closing the last selected tick, or immediately for length 0.
  assign finish = (state == BURST) &&
                  ((len_l == 8'd0) || (tick_sel && (bcnt + 8'd1 == len_l)));
  assign stay   = active && !stop && !finish;
  assign run_nx = go || stay;

  for (genvar n = 0; n < 3; n++) begin : g_ch
    localparam int D = (n == 0) ? DIV0 : ((n == 1) ? DIV1 : DIV2);
    localparam int W = $clog2(D);
    localparam logic [W-1:0] LAST = W'(D - 1);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nx;

    always_comb begin
      cnt_nx = '0;
      if (stay)
        cnt_nx = (cnt == LAST) ? '0 : cnt + W'(1);
    end

    // Registered tick: high in exactly the cycles whose counter value is LAST.
    assign tick_nx[n] = stay && (cnt_nx == LAST);

    always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt_nx;
    end
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel_l <= 2'd0;
      len_l <= 8'd0;
      bcnt  <= 8'd0;
      tick  <= 3'b000;
      sq    <= 3'b000;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      tick <= tick_nx;
      busy <= run_nx;
      done <= finish && !stop;
      // Square waves hold through DONE and clear once the state returns to IDLE.
      if (run_nx || (finish && !stop)) sq <= sq ^ tick;
      else                             sq <= 3'b000;

      case (state)
        IDLE: begin
          if (go) begin
            state <= burst_req ? BURST : RUN;
            sel_l <= sel_in;
            len_l <= len_in;
            bcnt  <= 8'd0;
          end
        end
        RUN: begin
          if (stop) state <= IDLE;
        end
        BURST: begin
          if (stop)          state <= IDLE;
          else if (finish)   state <= DONE;
          else if (tick_sel) bcnt  <= bcnt + 8'd1;
        end
        default: begin
          state <= IDLE;
          bcnt  <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dieu_khien_xung.sv
// Scoreboard bench for dieu_khien_xung with DIV0=8, DIV1=4, DIV2=2.
// Expected tick/done events are queued by the stimulus and matched by an output monitor.
module tb_dieu_khien_xung;

  logic       clki = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       burst = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [7:0] burst_len = 8'd0;
  logic [2:0] tick;
  logic [2:0] sq;
  logic       busy;
  logic       done;

  dieu_khien_xung #(.DIV0(8), .DIV1(4), .DIV2(2)) dut (
    .clki(clki), .rst_n(rst_n), .start(start), .stop(stop), .burst(burst),
    .sel(sel), .burst_len(burst_len), .tick(tick), .sq(sq), .busy(busy), .done(done)
  );

  always #5 clki = ~clki;

  typedef struct {
    int       cyc;
    logic [2:0] tk;
    logic     dn;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  base = 0;

  always @(posedge clki) cyc <= cyc + 1;

  // Monitor: every cycle showing a tick or done must match the next queued event.
  always @(negedge clki) begin
    if (rst_n && (tick != 3'b000 || done)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d tick=%b done=%b (no event expected)", cyc, tick, done);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.tk != tick || e.dn != done) begin
          bad++;
          $display("FAIL event got cyc=%0d tick=%b done=%b want cyc=%0d tick=%b done=%b",
                   cyc, tick, done, e.cyc, e.tk, e.dn);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input int c, input logic [2:0] tk, input logic dn);
    ev_t e;
    e.cyc = base + c;
    e.tk  = tk;
    e.dn  = dn;
    q.push_back(e);
  endtask

  // Continuous-mode tick pattern for spec cycles 1..last.
  task automatic expect_run(input int last);
    for (int c = 2; c <= last; c += 2) begin
      logic [2:0] t;
      t = 3'b100;
      if (c % 4 == 0) t[1] = 1'b1;
      if (c % 8 == 0) t[0] = 1'b1;
      expect_ev(c, t, 1'b0);
    end
  endtask

  // Issue start at this negedge; afterwards, at the negedge of spec cycle c, cyc == base + c.
  task automatic do_start(input logic b, input logic [1:0] s, input logic [7:0] len, input logic stp);
    start = 1'b1; stop = stp; burst = b; sel = s; burst_len = len;
    base = cyc;
    @(negedge clki);
    start = 1'b0; stop = 1'b0; burst = 1'b0; sel = 2'd0; burst_len = 8'd0;
  endtask

  task automatic to_cycle(input int c);
    while (cyc < base + c) @(negedge clki);
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_busy"}, {31'd0, busy}, 32'd0);
    check({nm, "_sq"}, {29'd0, sq}, 32'd0);
    check({nm, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d limit reached", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clki);
    check("rst_tick", {29'd0, tick}, 32'd0);
    check_idle("rst");
    rst_n = 1'b1;
    @(negedge clki);

    // Continuous run with a start issued mid-run that must not restart the phase.
    do_start(1'b0, 2'd0, 8'd0, 1'b0);
    expect_run(16);
    to_cycle(1);
    check("run_busy_c1", {31'd0, busy}, 32'd1);
    to_cycle(5);
    check("run_sq_c5", {29'd0, sq}, 32'h2);
    start = 1'b1;
    to_cycle(6);
    start = 1'b0;
    to_cycle(12);
    check("run_busy_c12", {31'd0, busy}, 32'd1);
    to_cycle(17);
    stop = 1'b1;
    to_cycle(18);
    stop = 1'b0;
    check_idle("run_stop");

    // start with stop in IDLE: nothing happens.
    do_start(1'b0, 2'd0, 8'd0, 1'b1);
    to_cycle(10);
    check("collide_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-run, then an immediate restart.
    do_start(1'b0, 2'd0, 8'd0, 1'b0);
    expect_run(8);
    to_cycle(3);
    check("pre_rst_sq", {29'd0, sq}, 32'h4);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("arst_tick", {29'd0, tick}, 32'd0);
    check_idle("arst");
    @(negedge clki);
    rst_n = 1'b1;
    do_start(1'b0, 2'd0, 8'd0, 1'b0);
    expect_run(4);
    to_cycle(1);
    check("restart_busy", {31'd0, busy}, 32'd1);
    to_cycle(5);
    stop = 1'b1;
    to_cycle(6);
    stop = 1'b0;
    check_idle("restart_stop");

`ifdef BURST_MODE_EN
    // Burst of 3 on channel 1.
    do_start(1'b1, 2'd1, 8'd3, 1'b0);
    expect_run(12);
    expect_ev(13, 3'b000, 1'b1);
    to_cycle(12);
    check("b3_busy_c12", {31'd0, busy}, 32'd1);
    to_cycle(13);
    check("b3_busy_c13", {31'd0, busy}, 32'd0);
    to_cycle(15);
    check_idle("b3_after");

    // Zero-length burst.
    do_start(1'b1, 2'd2, 8'd0, 1'b0);
    expect_ev(2, 3'b000, 1'b1);
    to_cycle(1);
    check("b0_busy_c1", {31'd0, busy}, 32'd1);
    to_cycle(4);
    check_idle("b0_after");

    // sel=3 maps to channel 0.
    do_start(1'b1, 2'd3, 8'd1, 1'b0);
    expect_run(8);
    expect_ev(9, 3'b000, 1'b1);
    to_cycle(11);
    check_idle("sel3_after");

    // Abort a 5-tick burst at cycle 6.
    do_start(1'b1, 2'd0, 8'd5, 1'b0);
    expect_run(6);
    to_cycle(6);
    stop = 1'b1;
    to_cycle(7);
    stop = 1'b0;
    check_idle("abort");
    to_cycle(12);
    check("abort_late_busy", {31'd0, busy}, 32'd0);
`else
    // Without burst support a burst request runs continuously.
    do_start(1'b1, 2'd2, 8'd0, 1'b0);
    expect_run(8);
    to_cycle(3);
    check("noburst_busy", {31'd0, busy}, 32'd1);
    to_cycle(9);
    stop = 1'b1;
    to_cycle(10);
    stop = 1'b0;
    check_idle("noburst_stop");
`endif

    repeat (3) @(negedge clki);
    check("pending_events", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
